// File: rtl/cursor_motion.sv
// rtl/cursor_motion.sv - accumulates relative mouse motion and applies it once per frame
//
// Purpose: drives the cursor/ball centre (X, Y) for the ball renderer. Motion packets
// from the mouse decoder are summed in saturating accumulators. On each rising edge of
// frame_clk, after it is synchronized, the sums are applied to X and then to Y. Both
// coordinates are clamped so the ball stays on screen. A one-cycle click pulse follows
// once X and Y are final.
//
// Ports:
//   Clk        in   1   system clock
//   Reset_n    in   1   asynchronous active-low reset
//   frame_clk  in   1   frame strobe, asynchronous to Clk
//   pkt_valid  in   1   motion packet present
//   pkt_ready  out  1   packet can be accepted this cycle (IDLE only)
//   pkt_dx     in   9   signed X motion, positive = right
//   pkt_dy     in   9   signed Y motion, positive = up
//   pkt_left   in   1   left-button state carried by the packet
//   X          out  10  cursor centre X
//   Y          out  10  cursor centre Y
//   click      out  1   one-cycle pulse: left press seen since the last update
module cursor_motion #(
  parameter logic [9:0] BALL_SIZE   = 10'd4,
  parameter logic [9:0] H_RES       = 10'd640,
  parameter logic [9:0] V_RES       = 10'd480,
  parameter logic [9:0] X_INIT      = 10'd320,
  parameter logic [9:0] Y_INIT      = 10'd240,
  parameter int         SPEED_SHIFT = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic signed [8:0] pkt_dx,
  input  logic signed [8:0] pkt_dy,
  input  logic              pkt_left,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  output logic              click
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] APPLY_X = 2'd1;
  localparam logic [1:0] APPLY_Y = 2'd2;

  localparam logic [9:0] X_MAX = H_RES - 10'd1 - BALL_SIZE;
  localparam logic [9:0] Y_MAX = V_RES - 10'd1 - BALL_SIZE;

  localparam logic signed [12:0] ACC_MAX = 13'sd2047;
  localparam logic signed [12:0] ACC_MIN = -13'sd2048;

  logic [1:0]         state;
  logic               fs_meta, fs_sync, fs_prev, frame_edge;
  logic signed [11:0] acc_x, acc_y, snap_x, snap_y;
  logic               press, snap_press, last_left;

  logic               accept;
  logic signed [11:0] acc_x_in, acc_y_in;
  logic               press_in;
  logic signed [11:0] dx_sh, dy_sh;
  logic signed [12:0] x_sum, y_sum;

  function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                 input logic signed [8:0]  d);
    logic signed [12:0] s;
    s = {a[11], a} + {{4{d[8]}}, d};
    if (s > ACC_MAX)      return ACC_MAX[11:0];
    else if (s < ACC_MIN) return ACC_MIN[11:0];
    else                  return s[11:0];
  endfunction

  function automatic logic [9:0] clamp(input logic signed [12:0] v,
                                       input logic [9:0]         lo,
                                       input logic [9:0]         hi);
    if (v < $signed({3'b000, lo}))      return lo;
    else if (v > $signed({3'b000, hi})) return hi;
    else                                return v[9:0];
  endfunction

  assign pkt_ready = (state == IDLE);
  assign accept    = pkt_valid & pkt_ready;

  // A packet accepted in the edge cycle must land in the snapshot, so the
  // snapshot takes these post-accept values rather than the registers.
  assign acc_x_in = accept ? sat_add(acc_x, pkt_dx) : acc_x;
  assign acc_y_in = accept ? sat_add(acc_y, pkt_dy) : acc_y;
  assign press_in = press | (accept & pkt_left & ~last_left);

  assign dx_sh = snap_x >>> SPEED_SHIFT;
  assign dy_sh = snap_y >>> SPEED_SHIFT;
  // 13-bit signed: 0..1023 plus or minus 2048 cannot overflow before the clamp.
  // Y subtracts because positive mouse dy means up and screen Y grows downward.
  assign x_sum = $signed({3'b000, X}) + {dx_sh[11], dx_sh};
  assign y_sum = $signed({3'b000, Y}) - {dy_sh[11], dy_sh};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_meta    <= 1'b0;
      fs_sync    <= 1'b0;
      fs_prev    <= 1'b0;
      frame_edge <= 1'b0;
    end else begin
      fs_meta    <= frame_clk;
      fs_sync    <= fs_meta;
      fs_prev    <= fs_sync;
      frame_edge <= fs_sync & ~fs_prev;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      X          <= X_INIT;
      Y          <= Y_INIT;
      click      <= 1'b0;
      acc_x      <= '0;
      acc_y      <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      press      <= 1'b0;
      snap_press <= 1'b0;
      last_left  <= 1'b0;
    end else begin
      click <= 1'b0;
      if (accept) last_left <= pkt_left;
      case (state)
        IDLE: begin
          if (frame_edge) begin
            snap_x     <= acc_x_in;
            snap_y     <= acc_y_in;
            snap_press <= press_in;
            acc_x      <= '0;
            acc_y      <= '0;
            press      <= 1'b0;
            state      <= APPLY_X;
          end else begin
            acc_x <= acc_x_in;
            acc_y <= acc_y_in;
            press <= press_in;
          end
        end
        // Edges seen in the two apply states are dropped on purpose.
        APPLY_X: begin
          X     <= clamp(x_sum, BALL_SIZE, X_MAX);
          state <= APPLY_Y;
        end
        APPLY_Y: begin
          Y     <= clamp(y_sum, BALL_SIZE, Y_MAX);
          click <= snap_press;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_motion.sv
// tb/tb_cursor_motion.sv - directed self-checking bench for cursor_motion
module tb_cursor_motion;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              frame_clk = 1'b0;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic signed [8:0] pkt_dx = '0;
  logic signed [8:0] pkt_dy = '0;
  logic              pkt_left = 1'b0;
  logic [9:0]        X, Y;
  logic              click;

  int tests = 0;
  int fails = 0;

  cursor_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_dx    (pkt_dx),
    .pkt_dy    (pkt_dy),
    .pkt_left  (pkt_left),
    .X         (X),
    .Y         (Y),
    .click     (click)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ends frame_clk low, then raises it. Returns 1 time unit into edge cycle E.
  task automatic frame_start();
    @(negedge Clk) frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic frame(input string tag, input int ex, input int ey, input int eclk);
    frame_start();
    @(posedge Clk); #1;
    check({tag, " rdy E+1"}, pkt_ready, 0);
    check({tag, " clk E+1"}, click, 0);
    @(posedge Clk); #1;
    check({tag, " X E+2"}, X, ex);
    check({tag, " rdy E+2"}, pkt_ready, 0);
    check({tag, " clk E+2"}, click, 0);
    @(posedge Clk); #1;
    check({tag, " X E+3"}, X, ex);
    check({tag, " Y E+3"}, Y, ey);
    check({tag, " clk E+3"}, click, eclk);
    check({tag, " rdy E+3"}, pkt_ready, 1);
    @(posedge Clk); #1;
    check({tag, " clk E+4"}, click, 0);
  endtask

  task automatic send(input int dx, input int dy, input logic left);
    @(negedge Clk);
    pkt_valid = 1'b1;
    pkt_dx    = 9'(dx);
    pkt_dy    = 9'(dy);
    pkt_left  = left;
    @(posedge Clk); #1;
    pkt_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk); #1;
    check("rst rdy", pkt_ready, 1);
    check("rst X", X, 320);
    @(negedge Clk) Reset_n = 1'b1;
    @(posedge Clk); #1;
    check("init X", X, 320);
    check("init Y", Y, 240);
    check("init click", click, 0);
    check("init rdy", pkt_ready, 1);

    for (int i = 0; i < 3; i++) frame("idle", 320, 240, 0);

    send(10, 5, 1'b0);
    frame("basic", 330, 235, 0);
    frame("nomove", 330, 235, 0);

    for (int i = 0; i < 20; i++) send(255, -255, 1'b0);
    frame("satpos", 635, 475, 0);
    for (int i = 0; i < 20; i++) send(-256, 255, 1'b0);
    frame("satneg", 4, 4, 0);

    // A packet offered in E is included. A packet offered in E+1 is held off until E+3.
    frame_start();
    pkt_valid = 1'b1; pkt_dx = 9'sd3; pkt_dy = 9'sd0; pkt_left = 1'b0;
    @(posedge Clk); #1;
    check("inE rdy E+1", pkt_ready, 0);
    pkt_dx = 9'sd5; pkt_dy = -9'sd2;
    @(posedge Clk); #1;
    check("inE X", X, 7);
    check("hold rdy E+2", pkt_ready, 0);
    @(posedge Clk); #1;
    check("inE Y", Y, 4);
    check("hold rdy E+3", pkt_ready, 1);
    @(posedge Clk); #1;
    pkt_valid = 1'b0;
    check("held X unchanged", X, 7);
    frame("held", 12, 6, 0);

    send(0, 0, 1'b0);
    send(0, 0, 1'b1);
    send(0, 0, 1'b1);
    send(0, 0, 1'b0);
    send(0, 0, 1'b1);
    frame("click", 12, 6, 1);
    frame("noclick", 12, 6, 0);

    // Reset during APPLY_X discards the pending motion.
    send(50, 0, 1'b0);
    frame_start();
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("midrst X", X, 320);
    check("midrst Y", Y, 240);
    check("midrst rdy", pkt_ready, 1);
    @(negedge Clk) Reset_n = 1'b1;
    frame("postrst", 320, 240, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
